// File: rtl/dpll_pkg.sv
// dpll_pkg: shared state encoding, loop defaults and saturating helper for the DPLL loop controller.
package dpll_pkg;
    localparam int N_BIT_DEF      = 8;
    localparam int CENTER_DEF     = 2048;
    localparam int LOCK_TOL_DEF   = 2;
    localparam int LOCK_COUNT_DEF = 4;

    typedef enum logic [2:0] {IDLE, WAIT, CAPTURE, INTEG, APPLY, HOLD} dpll_ctrl_state_t;

    // Clamp v into the signed range of a w-bit two's complement value.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return v > hi ? hi : v < lo ? lo : v;
    endfunction
endpackage

// File: rtl/dpll_pi_filter.sv
// dpll_pi_filter: combinational PI arithmetic producing the phase error, next integrator and clamped DCO word.
module dpll_pi_filter
    import dpll_pkg::*;
#(
    parameter int N_BIT    = N_BIT_DEF,
    parameter int CTRL_W   = 12,
    parameter int CENTER   = CENTER_DEF,
    parameter int ACC_W    = 20,
    parameter int KP_SHIFT = 2,
    parameter int KI_SHIFT = 4
) (
    input  logic [N_BIT-1:0]        diff_1,
    input  logic [N_BIT-1:0]        diff_2,
    input  logic signed [N_BIT:0]   err_q,
    input  logic signed [ACC_W-1:0] integ,
    output logic signed [N_BIT:0]   err,
    output logic signed [ACC_W-1:0] integ_next,
    output logic [CTRL_W-1:0]       dco_next
);
    localparam int SW = ACC_W + 1;
    logic signed [SW-1:0] integ_sum;
    logic signed [SW-1:0] dco_sum;
    assign err        = $signed({1'b0, diff_1}) - $signed({1'b0, diff_2});
    assign integ_sum  = SW'(integ) + SW'(err_q);
    assign integ_next = ACC_W'(sat_s(64'(integ_sum), ACC_W));
    // integ here is the value already updated by the capture step.
    assign dco_sum    = SW'(CENTER) + (SW'(err_q) <<< KP_SHIFT) + (SW'(integ) >>> KI_SHIFT);
    assign dco_next   = dco_sum < 0 ? '0 : dco_sum > SW'((1 << CTRL_W) - 1) ? '1 : dco_sum[CTRL_W-1:0];
endmodule

// File: rtl/dpll_loop_ctrl.sv
// dpll_loop_ctrl: sequences PFD measurements through a PI update to the DCO word and tracks lock.
module dpll_loop_ctrl
    import dpll_pkg::*;
#(
    parameter int N_BIT      = N_BIT_DEF,
    parameter int CTRL_W     = 12,
    parameter int CENTER     = CENTER_DEF,
    parameter int ACC_W      = 20,
    parameter int KP_SHIFT   = 2,
    parameter int KI_SHIFT   = 4,
    parameter int LOCK_TOL   = LOCK_TOL_DEF,
    parameter int LOCK_COUNT = LOCK_COUNT_DEF
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              enable,
    input  logic              pfd_ready,
    input  logic              pfd_timeout,
    input  logic [N_BIT-1:0]  pfd_diff_1,
    input  logic [N_BIT-1:0]  pfd_diff_2,
    output logic [CTRL_W-1:0] dco_word,
    output logic              update,
    output logic              locked,
    output logic              holding,
    output logic              overrun
);
    localparam int CW = $clog2(LOCK_COUNT + 1);
    dpll_ctrl_state_t        state;
    logic                    ready_q;
    logic                    sample;
    logic                    in_tol;
    logic signed [N_BIT:0]   err;
    logic signed [N_BIT:0]   err_q;
    logic [N_BIT:0]          err_abs;
    logic signed [ACC_W-1:0] integ;
    logic signed [ACC_W-1:0] integ_next;
    logic [CTRL_W-1:0]       dco_next;
    logic [CW-1:0]           lock_cnt;

    dpll_pi_filter #(
        .N_BIT(N_BIT), .CTRL_W(CTRL_W), .CENTER(CENTER),
        .ACC_W(ACC_W), .KP_SHIFT(KP_SHIFT), .KI_SHIFT(KI_SHIFT)
    ) u_pi (
        .diff_1(pfd_diff_1), .diff_2(pfd_diff_2), .err_q(err_q), .integ(integ),
        .err(err), .integ_next(integ_next), .dco_next(dco_next)
    );

    assign sample  = pfd_ready && !ready_q;
    assign err_abs = err_q < 0 ? $unsigned(-err_q) : $unsigned(err_q);
    assign in_tol  = err_abs <= (N_BIT + 1)'(LOCK_TOL);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            ready_q  <= 1'b0;
            err_q    <= '0;
            integ    <= '0;
            lock_cnt <= '0;
            dco_word <= CTRL_W'(CENTER);
            update   <= 1'b0;
            locked   <= 1'b0;
            holding  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            ready_q <= pfd_ready;
            update  <= 1'b0;
            overrun <= 1'b0;
            if (!enable) begin
                state    <= IDLE;
                integ    <= '0;
                lock_cnt <= '0;
                dco_word <= CTRL_W'(CENTER);
                locked   <= 1'b0;
                holding  <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= WAIT;
                    WAIT: begin
                        if (pfd_timeout) begin
                            state    <= HOLD;
                            holding  <= 1'b1;
                            locked   <= 1'b0;
                            lock_cnt <= '0;
                        end else if (sample) begin
                            err_q <= err;
                            state <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        integ    <= integ_next;
                        lock_cnt <= !in_tol ? '0 : lock_cnt == CW'(LOCK_COUNT) ? lock_cnt : lock_cnt + CW'(1);
                        if (!in_tol) locked <= 1'b0;
                        overrun  <= sample;
                        state    <= INTEG;
                    end
                    INTEG: begin
                        dco_word <= dco_next;
                        update   <= 1'b1;
                        if (lock_cnt == CW'(LOCK_COUNT)) locked <= 1'b1;
                        overrun  <= sample;
                        state    <= APPLY;
                    end
                    APPLY: begin
                        overrun <= sample;
                        state   <= WAIT;
                    end
                    HOLD: begin
                        overrun <= sample;
                        if (!pfd_timeout) begin
                            state   <= WAIT;
                            holding <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dpll_loop_ctrl.sv
// tb_dpll_loop_ctrl: directed scoreboard bench for the DPLL loop controller.
module tb_dpll_loop_ctrl;
    logic        Clock = 1'b0;
    logic        nReset;
    logic        enable;
    logic        pfd_ready;
    logic        pfd_timeout;
    logic [7:0]  pfd_diff_1;
    logic [7:0]  pfd_diff_2;
    logic [11:0] dco_word;
    logic        update;
    logic        locked;
    logic        holding;
    logic        overrun;

    int checks = 0;
    int failures = 0;

    typedef struct {
        longint dco;
        bit     lk;
    } exp_t;
    exp_t sb[$];

    longint m_integ = 0;
    int     m_cnt = 0;
    bit     m_locked = 0;
    longint m_dco = 2048;

    dpll_loop_ctrl dut (
        .Clock(Clock), .nReset(nReset), .enable(enable), .pfd_ready(pfd_ready),
        .pfd_timeout(pfd_timeout), .pfd_diff_1(pfd_diff_1), .pfd_diff_2(pfd_diff_2),
        .dco_word(dco_word), .update(update), .locked(locked), .holding(holding),
        .overrun(overrun)
    );

    always #5 Clock = ~Clock;

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        return v < lo ? lo : v > hi ? hi : v;
    endfunction

    function automatic longint floor16(input longint v);
        return v >= 0 ? v / 16 : -((-v + 15) / 16);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference model of one accepted sample; returns lock state just after capture.
    task automatic predict(input int d1, input int d2, output bit lock_cap);
        int e;
        e = d1 - d2;
        m_integ = clamp(m_integ + e, -524288, 524287);
        if ((e < 0 ? -e : e) <= 2) m_cnt = m_cnt < 4 ? m_cnt + 1 : 4;
        else begin
            m_cnt = 0;
            m_locked = 0;
        end
        lock_cap = m_locked;
        if (m_cnt == 4) m_locked = 1;
        m_dco = clamp(2048 + e * 4 + floor16(m_integ), 0, 4095);
        sb.push_back('{m_dco, m_locked});
    endtask

    task automatic do_sample(input int d1, input int d2);
        bit lc;
        predict(d1, d2, lc);
        pfd_diff_1 = 8'(d1);
        pfd_diff_2 = 8'(d2);
        pfd_ready = 1'b1;
        @(negedge Clock);
        pfd_ready = 1'b0;
        @(negedge Clock);
        chk("lock_at_capture", locked, lc);
        @(negedge Clock);
        chk("update_latency", update, 1);
        @(negedge Clock);
    endtask

    always @(negedge Clock) begin
        if (nReset && update) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_update observed=%0d expected=none", dco_word);
            end
            if (sb.size() != 0) begin
                exp_t x;
                x = sb.pop_front();
                checks++;
                assert (dco_word === 12'(x.dco) && locked === x.lk) else begin
                    failures++;
                    $error("FAIL sb_update observed=%0d/%0b expected=%0d/%0b", dco_word, locked, x.dco, x.lk);
                end
            end
        end
    end

    initial begin
        bit lc;
        nReset = 1'b0;
        enable = 1'b0;
        pfd_ready = 1'b0;
        pfd_timeout = 1'b0;
        pfd_diff_1 = '0;
        pfd_diff_2 = '0;
        repeat (2) @(negedge Clock);
        chk("rst_dco", dco_word, 2048);
        chk("rst_flags", {update, locked, holding, overrun}, 0);
        nReset = 1'b1;
        @(negedge Clock);
        chk("idle_dco", dco_word, 2048);
        enable = 1'b1;
        @(negedge Clock);
        do_sample(10, 0);
        chk("lead_first", dco_word, 2088);
        do_sample(10, 0);
        chk("lead_second", dco_word, 2089);
        repeat (4) do_sample(1, 0);
        chk("lock_set", locked, 1);
        do_sample(0, 5);
        chk("unlock_dco", dco_word, 2029);
        chk("unlock_flag", locked, 0);
        repeat (4) do_sample(0, 0);
        chk("relock", locked, 1);
        pfd_timeout = 1'b1;
        @(negedge Clock);
        chk("hold_flag", holding, 1);
        chk("hold_unlock", locked, 0);
        chk("hold_dco", dco_word, 2049);
        m_cnt = 0;
        m_locked = 0;
        pfd_ready = 1'b1;
        @(negedge Clock);
        chk("hold_overrun", overrun, 1);
        @(negedge Clock);
        chk("hold_overrun_end", overrun, 0);
        pfd_timeout = 1'b0;
        @(negedge Clock);
        chk("hold_exit", holding, 0);
        repeat (4) @(negedge Clock);
        chk("no_update_after_hold", update, 0);
        pfd_ready = 1'b0;
        @(negedge Clock);
        predict(3, 0, lc);
        pfd_diff_1 = 8'd3;
        pfd_diff_2 = 8'd0;
        pfd_ready = 1'b1;
        @(negedge Clock);
        pfd_ready = 1'b0;
        @(negedge Clock);
        chk("ovr_lock_cap", locked, lc);
        pfd_diff_1 = 8'd50;
        pfd_ready = 1'b1;
        @(negedge Clock);
        chk("ovr_update", update, 1);
        chk("ovr_pulse", overrun, 1);
        chk("ovr_dco", dco_word, 2061);
        pfd_ready = 1'b0;
        @(negedge Clock);
        chk("ovr_pulse_end", overrun, 0);
        @(negedge Clock);
        pfd_diff_1 = 8'd7;
        pfd_ready = 1'b1;
        @(negedge Clock);
        pfd_ready = 1'b0;
        @(negedge Clock);
        enable = 1'b0;
        @(negedge Clock);
        chk("en_drop_update", update, 0);
        chk("en_drop_dco", dco_word, 2048);
        m_integ = 0;
        m_cnt = 0;
        m_locked = 0;
        enable = 1'b1;
        @(negedge Clock);
        do_sample(10, 0);
        chk("restart_dco", dco_word, 2088);
        repeat (300) do_sample(255, 0);
        chk("sat_dco", dco_word, 4095);
        @(negedge Clock);
        #2 nReset = 1'b0;
        #1;
        chk("async_rst_dco", dco_word, 2048);
        chk("async_rst_flags", {update, locked, holding, overrun}, 0);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
